// File: rtl/psram_responder.sv
`default_nettype none
// ============================================================================
// Module   : psram_responder
// Purpose  : Memory-side octal PSRAM model; decodes the SDR cmd/addr stream and
//            serves reads/writes from an internal byte RAM.
// Revision : 1.0 - initial release
// ============================================================================
module psram_responder #(
    parameter int         ADDR_W    = 16,      // >= 9
    parameter int         LATENCY   = 4,       // >= 1
    parameter logic [7:0] CMD_WRITE = 8'h02,
    parameter logic [7:0] CMD_READ  = 8'h03
) (
    input  logic       clkRAM,
    input  logic       reset,
    input  logic       i_psram_cs,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_data_oe,
    output logic       o_busy,
    output logic       o_cmd_err
);

    localparam int DCNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DUMMY  = 3'd2,
        RDATA  = 3'd3,
        WDATA  = 3'd4,
        IGNORE = 3'd5
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [1:0]          byte_cnt;
    logic [DCNT_W-1:0]   dcnt;
    logic                is_write;
    logic [7:0]          mem [0:(2**ADDR_W)-1];

    assign o_busy = (state != IDLE);

    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            o_data    <= 8'h00;
            o_data_oe <= 1'b0;
            o_cmd_err <= 1'b0;
            addr      <= '0;
            byte_cnt  <= 2'd0;
            dcnt      <= '0;
            is_write  <= 1'b0;
        end else if (i_psram_cs) begin
            state     <= IDLE;
            o_data_oe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    byte_cnt <= 2'd0;
                    is_write <= (i_data == CMD_WRITE);
                    if (i_data == CMD_WRITE || i_data == CMD_READ) begin
                        o_cmd_err <= 1'b0;
                        state     <= ADDR;
                    end else begin
                        o_cmd_err <= 1'b1;
                        state     <= IGNORE;
                    end
                end
                ADDR: begin
                    // Three MSB-first shifts leave A[ADDR_W-1:0]; upper address bits fall off the top.
                    addr     <= {addr[ADDR_W-9:0], i_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd2) begin
                        dcnt  <= '0;
                        state <= is_write ? WDATA : DUMMY;
                    end
                end
                DUMMY: begin
                    dcnt <= dcnt + DCNT_W'(1);
                    if (dcnt == DCNT_W'(LATENCY - 1)) begin
                        o_data    <= mem[addr];
                        o_data_oe <= 1'b1;
                        addr      <= addr + ADDR_W'(1);
                        state     <= RDATA;
                    end
                end
                RDATA: begin
                    o_data <= mem[addr];
                    addr   <= addr + ADDR_W'(1);
                end
                WDATA: begin
                    addr <= addr + ADDR_W'(1);
                end
                IGNORE: begin
                    o_data_oe <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    o_data_oe <= 1'b0;
                end
            endcase
        end
    end

    // State is forced to IDLE asynchronously by reset, so no write can slip through it.
    always_ff @(posedge clkRAM) begin
        if (!i_psram_cs && state == WDATA) begin
            mem[addr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_responder
// Purpose  : Self-checking bench; LATENCY=4 and LATENCY=1 responders share the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psram_responder;

    localparam int LAT = 4;

    logic       clk;
    logic       reset;
    logic       cs;
    logic [7:0] din;
    logic [7:0] d0, d1;
    logic       oe0, oe1, busy0, busy1, err0, err1;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b1;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        logic [31:0] wdata;   // bytes MSB first
        logic [31:0] rexp;    // bytes MSB first
        bit          chk;     // also check first-byte timing on both builds
    } vec_t;

    psram_responder #(.ADDR_W(16), .LATENCY(LAT)) dut0 (
        .clkRAM(clk), .reset(reset), .i_psram_cs(cs), .i_data(din),
        .o_data(d0), .o_data_oe(oe0), .o_busy(busy0), .o_cmd_err(err0)
    );

    psram_responder #(.ADDR_W(16), .LATENCY(1)) dut1 (
        .clkRAM(clk), .reset(reset), .i_psram_cs(cs), .i_data(din),
        .o_data(d1), .o_data_oe(oe1), .o_busy(busy1), .o_cmd_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every byte driven while oe is high must match the oldest expected byte.
    always @(posedge clk) begin
        #1;
        if (mon_en && oe0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_oe", 32'(oe0), 32'(0));
            end else begin
                chk("rdata", 32'(d0), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic xfer(input vec_t v);
        @(negedge clk); cs = 1'b0; din = v.cmd;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); din = v.addr[23-8*i -: 8];
        end
        if (v.cmd == 8'h02) begin
            for (int i = 0; i < v.n; i++) begin
                @(negedge clk); din = v.wdata[31-8*i -: 8];
            end
        end else begin
            for (int i = 0; i < v.n; i++) exp_q.push_back(v.rexp[31-8*i -: 8]);
            @(posedge clk); #1;
            if (v.chk) chk("lat1_pre_oe", 32'(oe1), 32'(0));
            for (int e = 1; e < LAT + v.n; e++) begin
                @(posedge clk); #1;
                if (v.chk) begin
                    chk("oe_timing", 32'(oe0), 32'(e >= LAT));
                    if (e == 1) begin
                        chk("lat1_oe", 32'(oe1), 32'(1));
                        chk("lat1_data", 32'(d1), 32'(v.rexp[31:24]));
                    end
                end
            end
        end
        @(negedge clk); cs = 1'b1; din = 8'h00;
        @(negedge clk);
    endtask

    vec_t vecs [9];
    vec_t rd_c000;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h02, 24'h00C000, 1, 32'h1400_0000, 32'h0,         1'b0};
        vecs[1] = '{8'h03, 24'h00C000, 1, 32'h0,         32'h1400_0000, 1'b1};
        vecs[2] = '{8'h02, 24'h00FFFF, 3, 32'hAABB_CC00, 32'h0,         1'b0};
        vecs[3] = '{8'h03, 24'h00FFFF, 3, 32'h0,         32'hAABB_CC00, 1'b1};
        vecs[4] = '{8'h03, 24'h000000, 2, 32'h0,         32'hBBCC_0000, 1'b0};
        vecs[5] = '{8'h02, 24'h7F1234, 4, 32'h1122_3344, 32'h0,         1'b0};
        vecs[6] = '{8'h03, 24'h001235, 2, 32'h0,         32'h2233_0000, 1'b1};
        vecs[7] = '{8'h02, 24'h00C000, 0, 32'h0,         32'h0,         1'b0};
        vecs[8] = '{8'h03, 24'h00C000, 1, 32'h0,         32'h1400_0000, 1'b0};
        rd_c000 = vecs[8];

        reset = 1'b1; cs = 1'b1; din = 8'h00;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(d0), 32'(0));
        chk("rst_oe",   32'(oe0), 32'(0));
        chk("rst_busy", 32'(busy0), 32'(0));
        chk("rst_err",  32'(err0), 32'(0));
        reset = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 9; k++) xfer(vecs[k]);

        // Unknown opcode followed by bytes shaped like a write to C000.
        @(negedge clk); cs = 1'b0; din = 8'h55;
        @(posedge clk); #1;
        chk("bad_busy", 32'(busy0), 32'(1));
        @(negedge clk); din = 8'h00;
        @(negedge clk); din = 8'hC0;
        @(negedge clk); din = 8'h00;
        @(negedge clk); din = 8'h77;
        @(negedge clk); cs = 1'b1;
        @(negedge clk);
        chk("bad_err",  32'(err0), 32'(1));
        chk("bad_err1", 32'(err1), 32'(1));
        xfer(rd_c000);
        chk("err_clear", 32'(err0), 32'(0));

        // Write aborted after two address bytes.
        @(negedge clk); cs = 1'b0; din = 8'h02;
        @(negedge clk); din = 8'h00;
        @(negedge clk); din = 8'hC0;
        @(posedge clk); #1;
        chk("short_busy_mid", 32'(busy0), 32'(1));
        @(negedge clk); cs = 1'b1; din = 8'h99;
        @(posedge clk); #1;
        chk("short_busy_end", 32'(busy0), 32'(0));
        @(negedge clk);
        xfer(rd_c000);

        // Reset asserted mid-burst must drop oe/busy without a clock edge.
        mon_en = 1'b0;
        @(negedge clk); cs = 1'b0; din = 8'h03;
        @(negedge clk); din = 8'h00;
        @(negedge clk); din = 8'hC0;
        @(negedge clk); din = 8'h00;
        @(posedge clk);
        repeat (LAT) @(posedge clk);
        #1;
        chk("rst_rd_oe",   32'(oe0), 32'(1));
        chk("rst_rd_data", 32'(d0), 32'(8'h14));
        #2 reset = 1'b0;
        #1;
        chk("async_oe",    32'(oe0), 32'(0));
        chk("async_busy",  32'(busy0), 32'(0));
        chk("async_busy1", 32'(busy1), 32'(0));
        @(negedge clk); cs = 1'b1; reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        xfer(rd_c000);

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
